seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//   Holds a NUM_DIGITS-nibble display value and drives one shared seven_segs decoder through Digit/EnableSegs.
//   Enables one active-low anode at a time, with a blanking gap between digits to prevent ghosting.
//   Sits between the CPU display register (value/load) and the board's segment/anode pins.
// PARAMETERS
//   NUM_DIGITS    4      digits scanned; legal range 1..8
//   REFRESH_DIV   50000  clk cycles one digit is lit (SHOW length); >=1
//   BLANK_CYCLES  16     clk cycles all anodes are off before each digit (BLANK length); >=1
// PORTS
//   clk          in   1              rising-edge clock
//   rst_n        in   1              asynchronous reset, active low
//   en           in   1              1 = scan running, 0 = display dark
//   value        in   4*NUM_DIGITS   display value; nibble i = digit i, digit 0 = rightmost/LS
//   load         in   1              1-cycle strobe: capture value into pending register
//   lz_suppress  in   1              1 = blank leading zero digits
//   Digit        out  4              nibble to seven_segs decoder
//   EnableSegs   out  1              segment enable to seven_segs decoder
//   an           out  NUM_DIGITS     anode selects, active low, at most one low
//   frame_done   out  1              1-cycle pulse at the end of each full scan
// BEHAVIOUR
//   All outputs are registered.
//   Reset values:
//     - an = all 1s; Digit = 0; EnableSegs = 0; frame_done = 0.
//     - State IDLE; idx = 0; cnt = 0; pending = 0; active = 0.
//   Load path:
//     - load=1 -> pending <= value on that edge, regardless of en or state.
//     - active <= pending only at a frame boundary (no mid-frame tearing).
//   States:
//     - IDLE: an all 1s, EnableSegs 0. When en=1 -> BLANK with idx=0, cnt=0.
//     - BLANK: an all 1s, EnableSegs 0, Digit = active[idx].
//       After BLANK_CYCLES cycles (cnt == BLANK_CYCLES-1) -> SHOW, cnt=0.
//     - SHOW: an[idx]=0, all other anodes 1, Digit = active nibble idx.
//       EnableSegs = ~suppressed(idx).
//       After REFRESH_DIV cycles -> BLANK, cnt=0, and then:
//         * idx < NUM_DIGITS-1: idx <= idx+1.
//         * idx == NUM_DIGITS-1 (frame boundary): idx <= 0; frame_done=1 for exactly 1 cycle (the first BLANK cycle); active <= pending.
//   Slot and frame length: slot = BLANK_CYCLES + REFRESH_DIV cycles; frame = NUM_DIGITS * slot.
//   Suppression: suppressed(i) = lz_suppress & (i != 0) & (active nibbles i..NUM_DIGITS-1 all zero).
//     - Digit 0 is never suppressed, so value 0 shows a single "0".
//     - Suppression is evaluated on active, never on pending.
//   Load at a frame boundary: load and frame boundary on the same edge -> active <= value (bypass); pending <= value.
//   Load latency: a load is visible from the first SHOW of the next frame; it never becomes visible mid-frame.
//   en deasserted in any state:
//     - Next edge -> IDLE; an all 1s; EnableSegs 0; idx, cnt cleared; frame_done 0.
//     - pending and active retained.
//     - Re-enabling restarts at digit 0 BLANK.
//   rst_n low mid-scan: all state returns to reset values immediately (asynchronous).
//   Counter widths: cnt is wide enough for max(REFRESH_DIV, BLANK_CYCLES)-1; idx is clog2(NUM_DIGITS) bits, minimum 1.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 -> slot 6, frame 24)
//   1. Reset, then en=1, no load -> an cycles 1110,1101,1011,0111.
//      Each is low 4 cycles, separated by 2 cycles of 1111; Digit=0, EnableSegs=1 in SHOW.
//   2. load value=16'h12AF mid-frame -> current frame still shows 0000.
//      Next frame shows F,A,2,1 on an[0..3]; frame_done high exactly 1 cycle every 24 cycles.
//   3. lz_suppress=1, value=16'h0050 -> EnableSegs=0 during SHOW of digits 3 and 2; digits 1 and 0 show 5 and 0.
//      value=0 -> only digit 0 lit, showing 0.
//   4. load asserted on the frame-boundary edge with value=16'h9999 -> the very next frame shows 9s.
//   5. en dropped during SHOW of digit 2 -> next cycle an=1111, EnableSegs=0.
//      Re-enable -> scan restarts at BLANK for digit 0; the last loaded value is still shown.
//   6. rst_n pulsed low mid-SHOW (asynchronous, between edges) -> an=1111, EnableSegs=0, frame_done=0 immediately.
//      After release, active=0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits.
// Holds a pending/active display value pair, walks the digits one at a time with a
// blanking gap before each, and drives a shared segment decoder through Digit/EnableSegs.
// All outputs are registered and reflect the state entered on the same clock edge.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    lz_suppress,
  output logic [3:0]              Digit,
  output logic                    EnableSegs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   pending, active, active_n;
  logic            boundary;
  logic [NUM_DIGITS-1:0] supp_n;
  logic            zero_run;
  logic [3:0]      digit_sel;

  // Next-state logic: phase counter, digit index and frame-boundary value swap.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    active_n = active;
    boundary = 1'b0;
    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_CYCLES - 1)) begin
            state_n = SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == CW'(REFRESH_DIV - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            if (idx == IW'(NUM_DIGITS - 1)) begin
              // Frame boundary: a load on this very edge bypasses pending.
              idx_n    = '0;
              boundary = 1'b1;
              active_n = load ? value : pending;
            end else begin
              idx_n = idx + IW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Leading-zero suppression evaluated on the value that will be active next cycle.
  always_comb begin
    zero_run = 1'b1;
    supp_n   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (active_n[4*i +: 4] == 4'h0);
      supp_n[i] = lz_suppress & (i != 0) & zero_run;
    end
  end

  assign digit_sel = active_n[4*int'(idx_n) +: 4];

  // State, counters and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      pending <= '0;
      active  <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      active <= active_n;
      if (load) pending <= value;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      Digit      <= 4'h0;
      EnableSegs <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= '1;
      Digit      <= 4'h0;
      EnableSegs <= 1'b0;
      frame_done <= boundary;
      case (state_n)
        BLANK: Digit <= digit_sel;
        SHOW: begin
          an         <= ~(NUM_DIGITS'(1) << idx_n);
          Digit      <= digit_sel;
          EnableSegs <= ~supp_n[idx_n];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scenario tasks checking seg_scan_ctrl against a frame-position model.
// The model tracks the cycle position inside a frame and derives the expected pins
// arithmetically (slot = pos / slot_len, phase = pos % slot_len).
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + R;
  localparam int FRAME = N * SLOT;
  localparam int OW    = N + 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [4*N-1:0] value;
  logic           load;
  logic           lz_suppress;
  logic [3:0]     Digit;
  logic           EnableSegs;
  logic [N-1:0]   an;
  logic           frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .lz_suppress(lz_suppress), .Digit(Digit), .EnableSegs(EnableSegs),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit             m_run;
  int             m_pos;
  logic [4*N-1:0] m_pending, m_active;
  bit             m_fd, m_lz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_pending = '0; m_active = '0; m_fd = 0; m_lz = 0;
    end else begin
      m_fd = 0;
      m_lz = lz_suppress;
      if (!en) begin
        m_run = 0; m_pos = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0;
      end else begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_pos    = 0;
          m_fd     = 1;
          m_active = load ? value : m_pending;
        end
      end
      if (load) m_pending = value;
    end
  end

  function automatic logic [OW-1:0] expected();
    int slot, off;
    logic [N-1:0] an_e;
    logic [3:0]   dig_e;
    logic         es_e;
    logic [4*N-1:0] upper;
    if (!m_run) return {{N{1'b1}}, 4'h0, 1'b0, 1'b0};
    slot  = m_pos / SLOT;
    off   = m_pos % SLOT;
    upper = m_active >> (4 * slot);
    dig_e = upper[3:0];
    if (off < B) begin
      an_e = '1;
      es_e = 1'b0;
    end else begin
      an_e = ~(N'(1) << slot);
      es_e = !(m_lz && slot != 0 && upper == '0);
    end
    return {an_e, dig_e, es_e, m_fd};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {an, Digit, EnableSegs, frame_done};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0; lz_suppress = 1'b0;
    #12;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++; if (Digit !== 4'h0) begin errors++; $display("FAIL reset_digit got %h want 0", Digit); end
    checks++; if (EnableSegs !== 1'b0) begin errors++; $display("FAIL reset_es got %b want 0", EnableSegs); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", frame_done); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (observed() !== expected()) begin errors++; $display("FAIL reset_idle got %h want %h", observed(), expected()); end
  endtask

  task automatic test_scan_zero();
    int low_cnt [N];
    for (int i = 0; i < N; i++) low_cnt[i] = 0;
    en = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL scan_zero c=%0d got %h want %h", c, observed(), expected()); end
      for (int i = 0; i < N; i++) if (an[i] === 1'b0) low_cnt[i]++;
      if (an !== 4'b1111 && (Digit !== 4'h0 || EnableSegs !== 1'b1)) begin
        errors++; $display("FAIL scan_zero_show c=%0d digit=%h es=%b want 0/1", c, Digit, EnableSegs);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (low_cnt[i] != R) begin errors++; $display("FAIL scan_zero_lowcnt an[%0d] got %0d want %0d", i, low_cnt[i], R); end
    end
  endtask

  task automatic test_load_midframe();
    int fd_count = 0, last_fd = -1, gap_bad = 0;
    // Mid-frame load; the model keeps the old value until the boundary.
    while (m_pos != 8) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL load_mid_pre got %h want %h", observed(), expected()); end
    end
    value = 16'h12AF; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL load_mid c=%0d got %h want %h", c, observed(), expected()); end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0 && c - last_fd != FRAME) gap_bad++;
        last_fd = c; fd_count++;
      end
      @(negedge clk);
    end
    checks++;
    if (fd_count != 2 || gap_bad != 0) begin errors++; $display("FAIL load_mid_fd pulses=%0d badgaps=%0d want 2/0", fd_count, gap_bad); end
  endtask

  task automatic test_suppress();
    lz_suppress = 1'b1;
    value = 16'h0050; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL supp_0050 c=%0d got %h want %h", c, observed(), expected()); end
    end
    value = 16'h0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL supp_0000 c=%0d got %h want %h", c, observed(), expected()); end
      if (EnableSegs === 1'b1 && an !== 4'b1110) begin
        errors++; $display("FAIL supp_0000_lit an=%b want 1110 when lit", an);
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_boundary_load();
    int guard = 0;
    while (m_pos != FRAME - 1 && guard < 2 * FRAME) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (m_pos != FRAME - 1) begin errors++; $display("FAIL bnd_wait pos=%0d want %0d", m_pos, FRAME - 1); end
    value = 16'h9999; load = 1'b1;
    @(negedge clk); load = 1'b0; value = 16'h3333;
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL bnd_load c=%0d got %h want %h", c, observed(), expected()); end
      if (an !== 4'b1111 && Digit !== 4'h9) begin errors++; $display("FAIL bnd_load_nine c=%0d got %h want 9", c, Digit); end
      @(negedge clk);
    end
  endtask

  task automatic test_en_drop();
    int guard = 0;
    while (m_pos != 2 * SLOT + B + 1 && guard < 2 * FRAME) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (an !== 4'b1011) begin errors++; $display("FAIL en_drop_pre an got %b want 1011", an); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || EnableSegs !== 1'b0) begin
      errors++; $display("FAIL en_drop an=%b es=%b want 1111/0", an, EnableSegs);
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int c = 0; c < FRAME + 2; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL en_resume c=%0d got %h want %h", c, observed(), expected()); end
      if (c == B && (an !== 4'b1110 || Digit !== 4'h9)) begin
        errors++; $display("FAIL en_resume_first an=%b digit=%h want 1110/9", an, Digit);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (m_pos != B + 1 && guard < 2 * FRAME) begin
      @(negedge clk); guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || EnableSegs !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL async_rst an=%b es=%b fd=%b want 1111/0/0", an, EnableSegs, frame_done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < FRAME + 2; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL async_after c=%0d got %h want %h", c, observed(), expected()); end
      if (an !== 4'b1111 && Digit !== 4'h0) begin errors++; $display("FAIL async_active c=%0d got %h want 0", c, Digit); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== expected()) begin errors++; $display("FAIL random c=%0d got %h want %h", c, observed(), expected()); end
      load  = ($urandom_range(0, 9) == 0);
      value = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 40) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 70) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_midframe();
    test_suppress();
    test_boundary_load();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
